// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan_driver: digit data and controls in, multiplexed segment/anode drive out.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 6
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic                    lz_blank;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (
        output digits_in, dp_in, blink_mask, lz_blank,
        input  seg, dp, an, frame_done
    );

    modport slave (
        input  digits_in, dp_in, blink_mask, lz_blank,
        output seg, dp, an, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: per-slot dead cycle, frame-wrap input shadowing,
// leading-zero blanking, optional hex glyphs and per-digit blinking.
module seg_scan_driver #(
    parameter int NUM_DIGITS    = 6,
    parameter int SCAN_DIV      = 50000,
    parameter int BLINK_FRAMES  = 100,
    parameter int HEX_EN        = 0,
    parameter int AN_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW != 0}};
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    logic [CW-1:0]                cnt_q;
    logic [IW-1:0]                idx_q;
    logic                         dead_q;
    logic                         blink_q;
    logic [BW-1:0]                frm_q;
    logic [NUM_DIGITS-1:0][3:0]   dig_sh_q;
    logic [NUM_DIGITS-1:0]        dp_sh_q;
    logic [NUM_DIGITS-1:0]        mask_sh_q;
    logic                         lz_sh_q;
    logic [6:0]                   seg_q;
    logic                         dp_q;
    logic [NUM_DIGITS-1:0]        an_q;
    logic                         fd_q;

    logic                         tick;
    logic                         wrap;
    logic [NUM_DIGITS-1:0]        zero_above;
    logic [NUM_DIGITS-1:0]        sel;
    logic [3:0]                   code;
    logic [6:0]                   seg_d;
    logic                         dp_d;
    logic [NUM_DIGITS-1:0]        an_d;

    function automatic logic [6:0] seg_map(input logic [3:0] c);
        logic [6:0] s;
        s = SEG_OFF;
        case (c)
            4'd0:  s = 7'b0000001;
            4'd1:  s = 7'b1001111;
            4'd2:  s = 7'b0010010;
            4'd3:  s = 7'b0000110;
            4'd4:  s = 7'b1001100;
            4'd5:  s = 7'b0100100;
            4'd6:  s = 7'b0100000;
            4'd7:  s = 7'b0001111;
            4'd8:  s = 7'b0000000;
            4'd9:  s = 7'b0000100;
            4'd10: s = (HEX_EN != 0) ? 7'b0001000 : SEG_OFF;
            4'd11: s = (HEX_EN != 0) ? 7'b1100000 : SEG_OFF;
            4'd12: s = (HEX_EN != 0) ? 7'b0110001 : SEG_OFF;
            4'd13: s = (HEX_EN != 0) ? 7'b1000010 : SEG_OFF;
            4'd14: s = (HEX_EN != 0) ? 7'b0110000 : SEG_OFF;
            default: s = (HEX_EN != 0) ? 7'b0111000 : SEG_OFF;
        endcase
        return s;
    endfunction

    assign tick = (cnt_q == CW'(SCAN_DIV - 1));
    assign wrap = tick && (idx_q == IW'(NUM_DIGITS - 1));
    assign sel  = NUM_DIGITS'(1) << idx_q;
    assign code = dig_sh_q[idx_q];

    // zero_above[k]: shadow digits k..top are all zero
    always_comb begin
        zero_above = '0;
        zero_above[NUM_DIGITS-1] = (dig_sh_q[NUM_DIGITS-1] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--)
            zero_above[k] = zero_above[k+1] && (dig_sh_q[k] == 4'd0);
    end

    // Blink overrides everything, including the anode; LZ blanking keeps dp and anode.
    always_comb begin
        seg_d = seg_map(code);
        dp_d  = ~dp_sh_q[idx_q];
        an_d  = sel ^ AN_OFF;
        if (lz_sh_q && (idx_q != '0) && zero_above[idx_q])
            seg_d = SEG_OFF;
        if (blink_q && mask_sh_q[idx_q]) begin
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
            an_d  = AN_OFF;
        end
    end

    // dead_q resets high so the first post-reset cycle acts as digit 0's dead cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            dead_q    <= 1'b1;
            blink_q   <= 1'b0;
            frm_q     <= '0;
            dig_sh_q  <= '0;
            dp_sh_q   <= '0;
            mask_sh_q <= '0;
            lz_sh_q   <= 1'b0;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            an_q      <= AN_OFF;
            fd_q      <= 1'b0;
        end else begin
            cnt_q  <= tick ? '0 : cnt_q + CW'(1);
            dead_q <= tick;
            fd_q   <= wrap;
            if (tick) begin
                idx_q <= wrap ? '0 : idx_q + IW'(1);
                an_q  <= AN_OFF;
            end else if (dead_q) begin
                seg_q <= seg_d;
                dp_q  <= dp_d;
                an_q  <= an_d;
            end
            if (wrap) begin
                dig_sh_q  <= bus.digits_in;
                dp_sh_q   <= bus.dp_in;
                mask_sh_q <= bus.blink_mask;
                lz_sh_q   <= bus.lz_blank;
                if (frm_q == BW'(BLINK_FRAMES - 1)) begin
                    frm_q   <= '0;
                    blink_q <= ~blink_q;
                end else begin
                    frm_q <= frm_q + BW'(1);
                end
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 4-digit decimal and hex instances plus a 1-digit instance.
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  mask = '0;
    logic        lz = 1'b0;
    int          checks = 0;
    int          errors = 0;

    localparam logic [3:0][3:0] AN_EXP   = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0][3:0] DEAD_EXP = {4'hF, 4'hF, 4'hF, 4'hF};

    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(4)) bi0 ();
    seg_scan_if #(.NUM_DIGITS(4)) bi1 ();
    seg_scan_if #(.NUM_DIGITS(1)) bis ();

    assign bi0.digits_in = digits;  assign bi1.digits_in = digits;
    assign bi0.dp_in = dp_in;       assign bi1.dp_in = dp_in;
    assign bi0.blink_mask = mask;   assign bi1.blink_mask = mask;
    assign bi0.lz_blank = lz;       assign bi1.lz_blank = lz;
    assign bis.digits_in = digits[3:0];
    assign bis.dp_in = dp_in[0];
    assign bis.blink_mask = 1'b0;
    assign bis.lz_blank = lz;

    seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .HEX_EN(0), .AN_ACTIVE_LOW(1))
        dut (.clk(clk), .rst_n(rst_n), .bus(bi0));
    seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_FRAMES(2), .HEX_EN(1), .AN_ACTIVE_LOW(1))
        dut_hex (.clk(clk), .rst_n(rst_n), .bus(bi1));
    seg_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(4), .BLINK_FRAMES(2), .HEX_EN(0), .AN_ACTIVE_LOW(1))
        dut_one (.clk(clk), .rst_n(rst_n), .bus(bis));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Starts on a frame's dead cycle, ends on the next frame's dead cycle.
    task automatic capture(output logic [3:0][6:0] s, output logic [3:0][6:0] sh,
                           output logic [3:0][3:0] a, output logic [3:0][3:0] dead,
                           output logic [3:0] d, output logic stable,
                           output int fd_cnt, output logic fd_end);
        stable = 1'b1;
        fd_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            dead[k] = bi0.an;
            step(1);
            if (bi0.frame_done) fd_cnt++;
            s[k] = bi0.seg; sh[k] = bi1.seg; a[k] = bi0.an; d[k] = bi0.dp;
            for (int j = 0; j < 2; j++) begin
                step(1);
                if (bi0.frame_done) fd_cnt++;
                if (bi0.an !== a[k] || bi0.seg !== s[k] || bi0.dp !== d[k] || bi1.seg !== sh[k])
                    stable = 1'b0;
            end
            step(1);
            if (bi0.frame_done) fd_cnt++;
        end
        fd_end = bi0.frame_done;
    endtask

    task automatic test_reset();
        logic [3:0][6:0] s, sh, es;
        logic [3:0][3:0] a, dead;
        logic [3:0] d;
        logic stable, fd_end;
        int fd_cnt;
        rst_n = 1'b0;
        step(3);
        checks++;
        if ({bi0.seg, bi0.dp, bi0.an, bi0.frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got seg=%b dp=%b an=%b fd=%b want 1111111 1 1111 0",
                     bi0.seg, bi0.dp, bi0.an, bi0.frame_done);
        end
        digits = 16'h1234;
        rst_n = 1'b1;
        capture(s, sh, a, dead, d, stable, fd_cnt, fd_end);
        es = {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
        checks++;
        if (s !== es) begin errors++; $display("FAIL first_frame_zero seg=%h want %h", s, es); end
        checks++;
        if (a !== AN_EXP || dead !== DEAD_EXP) begin
            errors++; $display("FAIL first_frame_an an=%h dead=%h want %h %h", a, dead, AN_EXP, DEAD_EXP);
        end
        capture(s, sh, a, dead, d, stable, fd_cnt, fd_end);
        es = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
        checks++;
        if (s !== es) begin errors++; $display("FAIL digits_1234 seg=%h want %h", s, es); end
        checks++;
        if (a !== AN_EXP || dead !== DEAD_EXP || d !== 4'hF) begin
            errors++; $display("FAIL slots_1234 an=%h dead=%h dp=%b want %h %h 1111", a, dead, d, AN_EXP, DEAD_EXP);
        end
        checks++;
        if (stable !== 1'b1 || fd_cnt != 1 || fd_end !== 1'b1) begin
            errors++; $display("FAIL hold_and_frame stable=%b fd_cnt=%0d fd_end=%b want 1 1 1", stable, fd_cnt, fd_end);
        end
    endtask

    task automatic test_lz();
        logic [3:0][6:0] s, sh, es;
        logic [3:0][3:0] a, dead;
        logic [3:0] d;
        logic stable, fd_end;
        int fd_cnt;
        digits = 16'h0050;
        lz = 1'b1;
        capture(s, sh, a, dead, d, stable, fd_cnt, fd_end);
        capture(s, sh, a, dead, d, stable, fd_cnt, fd_end);
        es = {7'h7F, 7'h7F, 7'b0100100, 7'b0000001};
        checks++;
        if (s !== es || a !== AN_EXP) begin
            errors++; $display("FAIL lz_0050 seg=%h an=%h want %h %h", s, es, a, AN_EXP);
        end
        digits = 16'h0000;
        dp_in = 4'b1000;
        capture(s, sh, a, dead, d, stable, fd_cnt, fd_end);
        capture(s, sh, a, dead, d, stable, fd_cnt, fd_end);
        es = {7'h7F, 7'h7F, 7'h7F, 7'b0000001};
        checks++;
        if (s !== es || a !== AN_EXP) begin
            errors++; $display("FAIL lz_0000 seg=%h an=%h want %h %h", s, a, es, AN_EXP);
        end
        checks++;
        if (d !== 4'b0111) begin errors++; $display("FAIL lz_dp dp=%b want 0111", d); end
        dp_in = 4'b0000;
        lz = 1'b0;
    endtask

    task automatic test_hex();
        logic [3:0][6:0] s, sh, es;
        logic [3:0][3:0] a, dead;
        logic [3:0] d;
        logic stable, fd_end;
        int fd_cnt;
        digits = 16'hABCD;
        capture(s, sh, a, dead, d, stable, fd_cnt, fd_end);
        capture(s, sh, a, dead, d, stable, fd_cnt, fd_end);
        es = {7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010};
        checks++;
        if (sh !== es) begin errors++; $display("FAIL hex_on seg=%h want %h", sh, es); end
        es = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
        checks++;
        if (s !== es || a !== AN_EXP) begin
            errors++; $display("FAIL hex_off seg=%h an=%h want %h %h", s, a, es, AN_EXP);
        end
    endtask

    task automatic test_tearing();
        logic [3:0][6:0] s, sh, es;
        logic [3:0][3:0] a, dead;
        logic [3:0] d;
        logic stable, fd_end;
        int fd_cnt;
        digits = 16'h1111;
        capture(s, sh, a, dead, d, stable, fd_cnt, fd_end);
        fork
            begin
                repeat (6) @(posedge clk);
                #2 digits = 16'h2222;
            end
        join_none
        capture(s, sh, a, dead, d, stable, fd_cnt, fd_end);
        es = {7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111};
        checks++;
        if (s !== es || stable !== 1'b1) begin
            errors++; $display("FAIL no_tearing seg=%h stable=%b want %h 1", s, stable, es);
        end
        capture(s, sh, a, dead, d, stable, fd_cnt, fd_end);
        es = {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010};
        checks++;
        if (s !== es) begin errors++; $display("FAIL after_wrap seg=%h want %h", s, es); end
    endtask

    task automatic test_blink();
        logic [3:0][6:0] s, sh, es;
        logic [3:0][3:0] a, dead, ea;
        logic [3:0] d;
        logic stable, fd_end;
        int fd_cnt;
        rst_n = 1'b0;
        step(2);
        digits = 16'h1234;
        mask = 4'b0001;
        rst_n = 1'b1;
        for (int f = 0; f < 5; f++) begin
            capture(s, sh, a, dead, d, stable, fd_cnt, fd_end);
            if (f == 0) begin
                es = {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
                ea = AN_EXP;
            end else if (f == 1 || f == 4) begin
                es = {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100};
                ea = AN_EXP;
            end else begin
                es = {7'b1001111, 7'b0010010, 7'b0000110, 7'h7F};
                ea = {4'b0111, 4'b1011, 4'b1101, 4'b1111};
            end
            checks++;
            if (s !== es || a !== ea || d !== 4'hF) begin
                errors++;
                $display("FAIL blink_frame%0d seg=%h an=%h dp=%b want %h %h 1111", f, s, a, d, es, ea);
            end
            checks++;
            if (fd_cnt != 1 || fd_end !== 1'b1) begin
                errors++; $display("FAIL blink_fd%0d fd_cnt=%0d fd_end=%b want 1 1", f, fd_cnt, fd_end);
            end
        end
        mask = 4'b0000;
    endtask

    task automatic test_reset_mid();
        step(10);
        checks++;
        if (bi0.an !== 4'b1011) begin errors++; $display("FAIL mid_slot2 an=%b want 1011", bi0.an); end
        rst_n = 1'b0;
        step(1);
        checks++;
        if ({bi0.seg, bi0.dp, bi0.an} !== {7'h7F, 1'b1, 4'hF}) begin
            errors++; $display("FAIL mid_reset seg=%b dp=%b an=%b want 1111111 1 1111", bi0.seg, bi0.dp, bi0.an);
        end
        rst_n = 1'b1;
        step(1);
        checks++;
        if (bi0.an !== 4'b1110 || bi0.seg !== 7'b0000001) begin
            errors++; $display("FAIL restart_d0 an=%b seg=%b want 1110 0000001", bi0.an, bi0.seg);
        end
        step(2);
        checks++;
        if (bi0.an !== 4'b1110) begin errors++; $display("FAIL restart_hold an=%b want 1110", bi0.an); end
        step(1);
        checks++;
        if (bi0.an !== 4'b1111) begin errors++; $display("FAIL restart_tick an=%b want 1111", bi0.an); end
    endtask

    task automatic test_single();
        logic got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1);
            if (bis.frame_done) got = 1'b1;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL single_fd_timeout got=0 want 1"); end
        checks++;
        if (bis.an !== 1'b1) begin errors++; $display("FAIL single_dead an=%b want 1", bis.an); end
        for (int i = 1; i <= 4; i++) begin
            step(1);
            checks++;
            if ({bis.frame_done, bis.an} !== ((i == 4) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL single_cycle%0d fd=%b an=%b want %b", i, bis.frame_done, bis.an, (i == 4) ? 2'b11 : 2'b00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lz();
        test_hex();
        test_tearing();
        test_blink();
        test_reset_mid();
        test_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 6, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000, clk cycles per digit slot; legal minimum 2.
REQ-003 Parameter BLINK_FRAMES, default 100, full scan frames per blink half-period; legal minimum 1.
REQ-004 Parameter HEX_EN, default 0; when 1, codes 10..15 SHALL display as A,b,C,d,E,F.
REQ-005 Parameter AN_ACTIVE_LOW, default 1, sets the digit-enable polarity.
REQ-006 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 digits_in  input  4*NUM_DIGITS  BCD/hex codes; digit k in bits [4k+3:4k]; digit 0 is least significant.
REQ-009 dp_in  input  NUM_DIGITS  decimal-point request per digit, 1 = lit.
REQ-010 blink_mask  input  NUM_DIGITS  1 = digit participates in blinking.
REQ-011 lz_blank  input  1  1 = suppress leading zeros.
REQ-012 seg  output  7  segments {a,b,c,d,e,f,g} on seg[6:0]; active-low.
REQ-013 dp  output  1  decimal point; active-low.
REQ-014 an  output  NUM_DIGITS  one-hot digit enable; polarity per AN_ACTIVE_LOW.
REQ-015 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-016 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick = (count == SCAN_DIV-1).
REQ-017 On a tick edge, index SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-018 On the tick edge where index wraps to 0, frame_done SHALL be 1 for that one following cycle.
REQ-019 On the same wrap edge, shadow registers SHALL capture digits_in, dp_in, blink_mask and lz_blank; outputs decode only shadow values, with no mid-frame tearing.
REQ-020 Dead time: on every tick edge, an SHALL go all-inactive for exactly one clk cycle.
REQ-021 On the next edge after the dead cycle, seg, dp and an SHALL be driven for the new index and held until the next tick edge.
REQ-022 Segment map, active-low, for codes 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
REQ-023 With HEX_EN=1, codes 10..15 SHALL map to 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-024 With HEX_EN=0, codes 10..15 SHALL give seg=1111111.
REQ-025 Leading-zero blanking: digit k (k>=1) SHALL show seg=1111111 when shadow lz_blank=1 and all shadow digits k..NUM_DIGITS-1 equal 0.
REQ-026 Digit 0 SHALL never be leading-zero blanked.
REQ-027 A leading-zero-blanked digit SHALL still drive dp per shadow dp_in, with its anode active.
REQ-028 Blink phase SHALL toggle on the frame-wrap edge after every BLINK_FRAMES completed frames.
REQ-029 While blink phase = 1, any digit whose shadow blink_mask bit is 1 SHALL drive seg=1111111, dp=1 and keep its anode inactive.
REQ-030 Blink blanking SHALL take priority over leading-zero blanking and hex decoding.
REQ-031 NUM_DIGITS=1: index SHALL stay 0, every tick SHALL be a frame wrap, and frame_done SHALL pulse every SCAN_DIV cycles.
REQ-032 Input changes between frame wraps SHALL have no effect on the outputs until the next wrap.

Reset
REQ-033 While rst_n=0 at a clk edge: prescaler=0, index=0, blink phase=0, blink frame count=0, shadows=0, seg=1111111, dp=1, an all-inactive, frame_done=0.
REQ-034 Reset asserted mid-slot or mid-frame SHALL abort the scan; scanning SHALL restart from digit 0 with the full SCAN_DIV count.
REQ-035 The first frame after reset SHALL display the all-zero shadow until the first wrap captures inputs.

Verification (NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, AN_ACTIVE_LOW=1 unless stated)
REQ-036 Release reset, digits_in=16'h1234, lz_blank=0 -> after the first wrap, slots show seg 1001100, 0000110, 0010010, 1001111 for an 1110, 1101, 1011, 0111; each slot is 1 dead cycle (an=1111) plus 3 driven cycles.
REQ-037 digits_in=16'h0050, lz_blank=1 -> digits 3 and 2 show seg=1111111, digit 1 shows 0100100, digit 0 shows 0000001; with digits_in=16'h0000, only digit 0 is lit, showing 0000001.
REQ-038 HEX_EN=1, digits_in=16'hABCD -> digit 0 shows 1000010 and digit 3 shows 0001000; with HEX_EN=0 -> all four digits show 1111111.
REQ-039 blink_mask=4'b0001 -> digit 0 is visible for 2 frames, then an stays 1111 in its slot for 2 frames, repeating; digits 1..3 are unaffected; frame_done pulses every 16 cycles.
REQ-040 Change digits_in mid-frame from 16'h1111 to 16'h2222 -> the remaining slots still show 1; the new value appears only after the next frame_done.
REQ-041 Assert rst_n=0 for 1 cycle mid-slot at index 2 -> the next edge gives seg=1111111 and an=1111; scanning resumes at digit 0 and the next tick occurs 4 cycles after release.
